// File: rtl/dataram_pkg.sv
// Shared constants for the data-RAM responder: MMIO page base, register
// offsets and STATUS bit layout.
package dataram_pkg;

   localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FF00;

   localparam logic [7:0]  TXDATA_OFS  = 8'h00;
   localparam logic [7:0]  STATUS_OFS  = 8'h04;
   localparam logic [7:0]  CONTROL_OFS = 8'h08;

   localparam int unsigned ST_FULL      = 0;
   localparam int unsigned ST_EMPTY     = 1;
   localparam int unsigned ST_OVF       = 2;
   localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/streamfifo.sv
// Synchronous word FIFO; a push into a full FIFO is still accepted when a pop
// frees the head slot in the same cycle.
module streamfifo #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned FIFODEPTH = 8
) (
   input  logic                           clock,
   input  logic                           nreset,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               wdata,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(FIFODEPTH):0]     count,
   output logic                           accepted
);

   localparam int unsigned PW = $clog2(FIFODEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] store_q [FIFODEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             pop_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(FIFODEPTH));
   assign count    = count_q;
   assign pop_ok   = pop & ~empty;
   // When full, wr_ptr == rd_ptr: the head is read before the edge overwrites it.
   assign accepted = push & (~full | pop_ok);
   assign rdata    = empty ? '0 : store_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accepted) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accepted, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (accepted) store_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/dataram_responder.sv
// Data-RAM bus responder: word RAM with combinational read, plus an MMIO page
// carrying a TX stream FIFO, its STATUS register and a sticky overflow flag.
module dataram_responder
   import dataram_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned FIFODEPTH = 8
) (
   input  logic             clock,
   input  logic             nreset,
   input  logic             writeram,
   input  logic [WIDTH-1:0] ramaddress,
   input  logic [WIDTH-1:0] writeramdata,
   output logic [WIDTH-1:0] readramdata,
   output logic             outvalid,
   input  logic             outready,
   output logic [WIDTH-1:0] outdata,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(FIFODEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    idx;
   logic [7:0]       offs;
   logic             is_mmio;
   logic             ram_we;
   logic             tx_push;
   logic             ctrl_clr;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_accepted;
   logic [CW-1:0]    fifo_count;
   logic [WIDTH-1:0] status;
   logic             ovf_q, ovf_d;
   logic             unused_addr_lsbs;

   assign unused_addr_lsbs = ^ramaddress[1:0];

   assign is_mmio  = &ramaddress[WIDTH-1:8];
   assign offs     = {ramaddress[7:2], 2'b00};
   assign idx      = ramaddress[AW+1:2];
   assign ram_we   = writeram & ~is_mmio;
   assign tx_push  = writeram & is_mmio & (offs == TXDATA_OFS);
   assign ctrl_clr = writeram & is_mmio & (offs == CONTROL_OFS) & writeramdata[0];

   always_ff @(posedge clock) begin
      if (ram_we) mem_q[idx] <= writeramdata;
   end

   streamfifo #(
      .WIDTH     (WIDTH),
      .FIFODEPTH (FIFODEPTH)
   ) u_fifo (
      .clock    (clock),
      .nreset   (nreset),
      .push     (tx_push),
      .pop      (outvalid & outready),
      .wdata    (writeramdata),
      .rdata    (outdata),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .accepted (fifo_accepted)
   );

   assign outvalid = ~fifo_empty;
   assign overflow = ovf_q;

   // A dropped push in the same cycle as a CONTROL clear leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (ctrl_clr)                  ovf_d = 1'b0;
      if (tx_push & ~fifo_accepted)  ovf_d = 1'b1;
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) ovf_q <= 1'b0;
      else         ovf_q <= ovf_d;
   end

   always_comb begin
      status                       = '0;
      status[ST_FULL]              = fifo_full;
      status[ST_EMPTY]             = fifo_empty;
      status[ST_OVF]               = ovf_q;
      status[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
   end

   always_comb begin
      readramdata = '0;
      if (!is_mmio)                 readramdata = mem_q[idx];
      else if (offs == STATUS_OFS)  readramdata = status;
   end

endmodule

// File: tb/tb_dataram_responder.sv
// Directed self-checking bench for dataram_responder: RAM access, TX stream
// ordering, overflow handling, backpressure and asynchronous reset.
module tb_dataram_responder;

   localparam logic [31:0] TX  = 32'hFFFF_FF00;
   localparam logic [31:0] ST  = 32'hFFFF_FF04;
   localparam logic [31:0] CTL = 32'hFFFF_FF08;

   logic        clock = 1'b0;
   logic        nreset;
   logic        writeram;
   logic [31:0] ramaddress;
   logic [31:0] writeramdata;
   logic [31:0] readramdata;
   logic        outvalid;
   logic        outready;
   logic [31:0] outdata;
   logic        overflow;

   int unsigned checks = 0;
   int unsigned errors = 0;

   dataram_responder #(
      .WIDTH     (32),
      .DEPTH     (1024),
      .FIFODEPTH (8)
   ) dut (
      .clock        (clock),
      .nreset       (nreset),
      .writeram     (writeram),
      .ramaddress   (ramaddress),
      .writeramdata (writeramdata),
      .readramdata  (readramdata),
      .outvalid     (outvalid),
      .outready     (outready),
      .outdata      (outdata),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      writeram     = 1'b1;
      ramaddress   = a;
      writeramdata = d;
      tick();
      writeram     = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      ramaddress = a;
      #1;
      d = readramdata;
   endtask

   logic [31:0] r;
   logic [31:0] q[$];
   int          sent;
   int          rcvd;
   logic        do_push;
   logic        rdy;

   initial begin
      nreset       = 1'b0;
      writeram     = 1'b0;
      ramaddress   = '0;
      writeramdata = '0;
      outready     = 1'b0;
      #2;
      check("rst_valid", 32'(outvalid), 32'd0);
      check("rst_data", outdata, 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      rd(ST, r);
      check("rst_status", r, 32'h0000_0002);
      #10 nreset = 1'b1;
      tick();

      // RAM write, read, alias, read-during-write
      wr(32'h40, 32'h1234_5678);
      rd(32'h40, r);
      check("ram_rd", r, 32'h1234_5678);
      rd(32'h40 + 32'd4096, r);
      check("ram_alias", r, 32'h1234_5678);
      rd(32'h43, r);
      check("ram_lsb_ignored", r, 32'h1234_5678);
      writeram = 1'b1; ramaddress = 32'h40; writeramdata = 32'hAA;
      #1;
      check("ram_rdw_old", readramdata, 32'h1234_5678);
      tick();
      writeram = 1'b0;
      rd(32'h40, r);
      check("ram_rdw_new", r, 32'h0000_00AA);
      rd(32'hFFFF_FF0C, r);
      check("mmio_other", r, 32'd0);

      // TX stream ordering
      wr(TX, 32'h11); wr(TX, 32'h22); wr(TX, 32'h33);
      rd(ST, r);
      check("tx_status3", r, 32'h0000_0300);
      rd(TX, r);
      check("tx_read0", r, 32'd0);
      check("tx_valid", 32'(outvalid), 32'd1);
      outready = 1'b1;
      #1;
      check("tx_d0", outdata, 32'h11);
      tick();
      check("tx_d1", outdata, 32'h22);
      tick();
      check("tx_d2", outdata, 32'h33);
      tick();
      check("tx_drained_valid", 32'(outvalid), 32'd0);
      check("tx_drained_data", outdata, 32'd0);
      outready = 1'b0;
      rd(ST, r);
      check("tx_status_empty", r, 32'h0000_0002);

      // Overflow: ninth push dropped
      for (int i = 0; i < 9; i++) wr(TX, 32'h100 + 32'(i));
      check("ovf_flag", 32'(overflow), 32'd1);
      rd(ST, r);
      check("ovf_status", r, 32'h0000_0805);
      wr(CTL, 32'h1);
      check("ovf_cleared", 32'(overflow), 32'd0);
      rd(ST, r);
      check("ovf_status_clr", r, 32'h0000_0801);
      outready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("ovf_drain", outdata, 32'h100 + 32'(i));
         tick();
      end
      check("ovf_drain_end", 32'(outvalid), 32'd0);
      outready = 1'b0;

      // Full FIFO with a pop in the same cycle accepts the push
      for (int i = 0; i < 8; i++) wr(TX, 32'h200 + 32'(i));
      outready = 1'b1;
      wr(TX, 32'h99);
      outready = 1'b0;
      check("fullpop_ovf", 32'(overflow), 32'd0);
      rd(ST, r);
      check("fullpop_status", r, 32'h0000_0801);
      outready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("fullpop_drain", outdata, (i == 7) ? 32'h99 : 32'h201 + 32'(i));
         tick();
      end
      check("fullpop_end", 32'(outvalid), 32'd0);
      outready = 1'b0;

      // Backpressure with random outready
      sent = 0;
      rcvd = 0;
      for (int cyc = 0; cyc < 2000 && (sent < 100 || q.size() > 0); cyc++) begin
         do_push      = (sent < 100) && (q.size() < 8) && ($urandom_range(0, 3) != 0);
         rdy          = 1'($urandom_range(0, 1));
         writeram     = do_push;
         ramaddress   = TX;
         writeramdata = 32'hC000 + 32'(sent);
         outready     = rdy;
         #1;
         check("bp_valid", 32'(outvalid), 32'(q.size() != 0));
         check("bp_data", outdata, (q.size() != 0) ? q[0] : 32'd0);
         @(posedge clock);
         if (rdy && q.size() != 0) begin
            void'(q.pop_front());
            rcvd++;
         end
         if (do_push) begin
            q.push_back(32'hC000 + 32'(sent));
            sent++;
         end
         #1;
      end
      writeram = 1'b0;
      outready = 1'b0;
      check("bp_rcvd", 32'(rcvd), 32'd100);
      check("bp_ovf", 32'(overflow), 32'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 9; i++) wr(TX, 32'hD0 + 32'(i));
      check("pre_rst_valid", 32'(outvalid), 32'd1);
      check("pre_rst_ovf", 32'(overflow), 32'd1);
      #3 nreset = 1'b0;
      #1;
      check("arst_valid", 32'(outvalid), 32'd0);
      check("arst_data", outdata, 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      #2 nreset = 1'b1;
      tick();
      rd(32'h40, r);
      check("arst_ram", r, 32'h0000_00AA);
      rd(ST, r);
      check("arst_status", r, 32'h0000_0002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
